pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core.
- Sits beside the decode stage and keeps a shadow copy of the register-use and destination fields of the instructions in EX, MEM and WB.
- From these it drives PC/IF-ID write enables, flushes, ID/EX bubble insertion and the two EX-stage operand forwarding selects.
- Handles load-use stalls, taken-branch and jump redirects, and external memory-busy freezes.
- Keeps saturating stall/flush counters.

---
 rtl/pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Tracks the instructions in EX/MEM/WB and, from the decode-stage fields,
// produces stall/flush/bubble control, EX operand forwarding selects, a
// small informational FSM and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_regwe,
    input  logic             id_load,
    input  logic             id_jump,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       regwe;
        logic       load;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_FREEZE  = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // A slot produces a value a consumer needs: real writer, not $0, same register.
    function automatic logic slot_hit(slot_t s, logic used, logic [4:0] src);
        return s.valid && s.regwe && (s.dst != 5'd0) && used && (src == s.dst);
    endfunction

    // MEM wins over WB because it holds the younger result; a load in MEM has
    // no data yet, so it can never be the forwarding source.
    function automatic logic [1:0] fwd_sel(slot_t mem_s, slot_t wb_s, logic used, logic [4:0] src);
        if (slot_hit(mem_s, used, src) && !mem_s.load) return FWD_MEM;
        else if (slot_hit(wb_s, used, src))            return FWD_WB;
        else                                           return FWD_RF;
    endfunction

    slot_t  ex_q, mem_q, wb_q;
    slot_t  id_slot;
    state_t state_q;
    logic   load_use;
    logic   advance;

    assign load_use = ex_q.load && (slot_hit(ex_q, id_use_rs, id_rs) ||
                                    slot_hit(ex_q, id_use_rt, id_rt));
    assign advance  = !mem_busy;
    assign state    = state_q;

    // Priority decode of the pipeline enables for the instruction now in ID.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (ex_br_taken) begin
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // EX operand selects from the EX slot sources against MEM and WB writers.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!rst && ex_q.valid) begin
            fwd_a = fwd_sel(mem_q, wb_q, ex_q.use_rs, ex_q.rs);
            fwd_b = fwd_sel(mem_q, wb_q, ex_q.use_rt, ex_q.rt);
        end
    end

    // Decode fields packed as the next EX slot; a bubble makes it invalid.
    always_comb begin
        id_slot = '{valid:  id_valid && !idex_bubble,
                    dst:    id_dst,
                    regwe:  id_regwe,
                    load:   id_load,
                    rs:     id_rs,
                    rt:     id_rt,
                    use_rs: id_use_rs,
                    use_rt: id_use_rt};
    end

    // Shadow slots shift EX->MEM->WB unless the memory freezes the pipe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so the shift
        // reads every slot's old value in the same edge.
        if (rst) begin
            // NOTE: whole slots are cleared, not just valid, so the hidden
            // fields never carry stale X/old data into debug views.
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (advance) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= id_slot;
        end
    end

    // Informational state: RUN, one-cycle LDSTALL, FREEZE while memory busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else if (mem_busy) begin
            state_q <= ST_FREEZE;
        end else begin
            case (state_q)
                ST_RUN:     state_q <= (load_use && !ex_br_taken) ? ST_LDSTALL : ST_RUN;
                ST_LDSTALL: state_q <= ST_RUN;
                ST_FREEZE:  state_q <= ST_RUN;
                default:    state_q <= ST_RUN;
            endcase
        end
    end

    // Saturating event counters; frozen cycles count nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (advance) begin
            if (ex_br_taken || (!load_use && id_jump)) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            end else if (load_use) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Fields kept in the slots for visibility but not needed by the logic.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{mem_q.rs, mem_q.rt, mem_q.use_rs, mem_q.use_rt,
                                wb_q.load, wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt};

    // The bubble moves the load to MEM, so a stall right after a stall means
    // the slot bookkeeping is broken.
    a_no_double_stall: assert property (@(posedge clk) disable iff (rst)
        !(state_q == ST_LDSTALL && !mem_busy && !ex_br_taken && load_use));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a driver applies one decode-cycle
// vector per clock and queues the hand-computed outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [1:0] RUN = 2'b00;
    localparam logic [1:0] LDS = 2'b01;
    localparam logic [1:0] FRZ = 2'b10;
    localparam int SAT = (1 << CNT_W) - 1;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       we;
        logic       ld;
        logic       jmp;
    } instr_t;

    typedef struct {
        string            nm;
        logic             pc;
        logic             ifid;
        logic             fl;
        logic             bub;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs, id_rt, id_dst;
    logic             id_use_rs, id_use_rt, id_regwe, id_load, id_jump;
    logic             ex_br_taken, mem_busy;
    logic             pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [1:0]       fwd_a, fwd_b, state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_regwe(id_regwe), .id_load(id_load), .id_jump(id_jump),
        .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic instr_t nop();
        instr_t i = '{v: 1'b0, rs: 5'd0, rt: 5'd0, urs: 1'b0, urt: 1'b0,
                      dst: 5'd0, we: 1'b0, ld: 1'b0, jmp: 1'b0};
        return i;
    endfunction

    function automatic instr_t rtype(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        instr_t i = nop();
        i.v = 1'b1; i.rs = rs; i.rt = rt; i.urs = 1'b1; i.urt = 1'b1;
        i.dst = rd; i.we = 1'b1;
        return i;
    endfunction

    function automatic instr_t itype(logic [4:0] rt, logic [4:0] rs, logic is_load);
        instr_t i = nop();
        i.v = 1'b1; i.rs = rs; i.rt = rt; i.urs = 1'b1;
        i.dst = rt; i.we = 1'b1; i.ld = is_load;
        return i;
    endfunction

    function automatic instr_t jmp();
        instr_t i = nop();
        i.v = 1'b1; i.jmp = 1'b1;
        return i;
    endfunction

    // Apply one decode cycle and queue the outputs expected during it.
    task automatic step(input string nm, input instr_t id, input logic br, input logic busy,
                        input logic r, input logic pc, input logic ifid, input logic fl,
                        input logic bub, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [1:0] st, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ex_br_taken = br; mem_busy = busy;
        id_valid = id.v; id_rs = id.rs; id_rt = id.rt;
        id_use_rs = id.urs; id_use_rt = id.urt; id_dst = id.dst;
        id_regwe = id.we; id_load = id.ld; id_jump = id.jmp;
        e.nm = nm; e.pc = pc; e.ifid = ifid; e.fl = fl; e.bub = bub;
        e.fa = fa; e.fb = fb; e.st = st;
        e.sc = sc[CNT_W-1:0]; e.fc = fc[CNT_W-1:0];
        exp_q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        n_vec++;
        if ({pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, state, stall_cnt, flush_cnt} !==
            {e.pc, e.ifid, e.fl, e.bub, e.fa, e.fb, e.st, e.sc, e.fc}) begin
            n_bad++;
            $display("FAIL %s: got pc_we=%b ifid_we=%b flush=%b bubble=%b fa=%b fb=%b st=%b sc=%0d fc=%0d, want pc_we=%b ifid_we=%b flush=%b bubble=%b fa=%b fb=%b st=%b sc=%0d fc=%0d",
                     e.nm, pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, state,
                     stall_cnt, flush_cnt, e.pc, e.ifid, e.fl, e.bub, e.fa, e.fb, e.st, e.sc, e.fc);
        end
    endtask

    // Monitor: the DUT presents a decode decision every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_br_taken = 1'b0; mem_busy = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_dst = '0; id_regwe = 1'b0; id_load = 1'b0; id_jump = 1'b0;
        repeat (2) @(posedge clk);

        //    name         ID instr              br busy rst  pc if fl bb  fa     fb     st   sc fc
        step("reset",      nop(),                0, 0, 1,     0, 0, 1, 1, 2'b00, 2'b00, RUN, 0, 0);
        // LW $2,0($1) ; ADD $3,$2,$4
        step("lw",         itype(2, 1, 1),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 0, 0);
        step("lu_stall",   rtype(3, 2, 4),       0, 0, 0,     0, 0, 0, 1, 2'b00, 2'b00, RUN, 0, 0);
        step("lu_reissue", rtype(3, 2, 4),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, LDS, 1, 0);
        step("lu_fwd_wb",  nop(),                0, 0, 0,     1, 1, 0, 0, 2'b01, 2'b00, RUN, 1, 0);
        // ADDI $5,$0,7 ; SUB $6,$5,$5
        step("addi",       itype(5, 0, 0),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        step("sub",        rtype(6, 5, 5),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        step("sub_fwd_mem",nop(),                0, 0, 0,     1, 1, 0, 0, 2'b10, 2'b10, RUN, 1, 0);
        // ADD $0,$1,$2 ; OR $3,$0,$0
        step("add_r0",     rtype(0, 1, 2),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        step("or_r0",      rtype(3, 0, 0),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        step("r0_no_fwd",  nop(),                0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        // ADD $7,$1,$1 ; ADD $7,$2,$2 ; SUB $8,$7,$9 -> MEM beats WB
        step("add7a",      rtype(7, 1, 1),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        step("add7b",      rtype(7, 2, 2),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        step("sub8",       rtype(8, 7, 9),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        step("mem_over_wb",nop(),                0, 0, 0,     1, 1, 0, 0, 2'b10, 2'b00, RUN, 1, 0);
        // Taken branch while a load-use pair sits in EX/ID: branch wins
        step("lw2",        itype(2, 1, 1),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 0);
        step("br_vs_lu",   rtype(3, 2, 4),       1, 0, 0,     1, 0, 1, 1, 2'b00, 2'b00, RUN, 1, 0);
        step("after_br",   nop(),                0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 1);
        // J in ID while memory busy for 3 cycles
        step("j_busy0",    jmp(),                0, 1, 0,     0, 0, 0, 0, 2'b00, 2'b00, RUN, 1, 1);
        step("j_busy1",    jmp(),                0, 1, 0,     0, 0, 0, 0, 2'b00, 2'b00, FRZ, 1, 1);
        step("j_busy2",    jmp(),                0, 1, 0,     0, 0, 0, 0, 2'b00, 2'b00, FRZ, 1, 1);
        step("j_flush",    jmp(),                0, 0, 0,     1, 0, 1, 0, 2'b00, 2'b00, FRZ, 1, 1);
        step("after_j",    nop(),                0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, 2);
        // Busy together with a taken branch: freeze first, redirect after
        step("br_busy",    nop(),                1, 1, 0,     0, 0, 0, 0, 2'b00, 2'b00, RUN, 1, 2);
        step("br_release", nop(),                1, 0, 0,     1, 0, 1, 1, 2'b00, 2'b00, FRZ, 1, 2);
        // 2^CNT_W+5 taken branches saturate flush_cnt
        for (int k = 0; k < (1 << CNT_W) + 5; k++)
            step("sat_br",  nop(),                1, 0, 0,     1, 0, 1, 1, 2'b00, 2'b00, RUN, 1,
                 (3 + k > SAT) ? SAT : 3 + k);
        step("sat_hold",   nop(),                0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, SAT);
        // Reset in the middle of a load-use stall
        step("lw3",        itype(2, 1, 1),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 1, SAT);
        step("lu_stall2",  rtype(3, 2, 4),       0, 0, 0,     0, 0, 0, 1, 2'b00, 2'b00, RUN, 1, SAT);
        step("rst_in_lds", rtype(3, 2, 4),       0, 0, 1,     0, 0, 1, 1, 2'b00, 2'b00, LDS, 2, SAT);
        step("post_rst",   rtype(3, 2, 4),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 0, 0);
        step("slots_clear",nop(),                0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 0, 0);
        // Reset with a load in EX: the pending load must be discarded
        step("lw4",        itype(2, 1, 1),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 0, 0);
        step("rst_ex_ld",  rtype(3, 2, 4),       0, 0, 1,     0, 0, 1, 1, 2'b00, 2'b00, RUN, 0, 0);
        step("no_stale_lu",rtype(3, 2, 4),       0, 0, 0,     1, 1, 0, 0, 2'b00, 2'b00, RUN, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
